// File: rtl/data_mem_arbiter.sv
// Two-port data memory arbiter: port 0 (CPU) has priority, port 1 (DMA) wins after
// STARVE_LIMIT consecutive denied cycles. Read data is registered back to the granted port.
`timescale 1ns/1ps

module data_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4,
    parameter int MODE_W       = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req,
    input  logic [31:0]       p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [MODE_W-1:0] p0_mode,
    input  logic              p0_rd,
    input  logic              p0_wr,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,

    input  logic              p1_req,
    input  logic [31:0]       p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic [MODE_W-1:0] p1_mode,
    input  logic              p1_rd,
    input  logic              p1_wr,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,

    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [MODE_W-1:0] mem_mode,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata,

    output logic              starve
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_e;

    owner_e              owner_q, owner_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                rd_pend_q, rd_pend_d;
    logic [31:0]         p0_rdata_q, p0_rdata_d;
    logic [31:0]         p1_rdata_q, p1_rdata_d;

    logic                starve_s;
    logic                p0_gnt_s, p1_gnt_s;
    logic                sel_rd_s, sel_wr_s;
    logic [31:0]         sel_addr_s, sel_wdata_s;
    logic [MODE_W-1:0]   sel_mode_s;
    logic                mem_read_s, mem_write_s;
    logic                p0_rvalid_s, p1_rvalid_s;

    // Grant decision; rst_n gates grants so nothing reaches memory during reset.
    always_comb begin
        starve_s = (wait_cnt_q == CNT_W'(STARVE_LIMIT));
        p1_gnt_s = rst_n & p1_req & (~p0_req | starve_s);
        p0_gnt_s = rst_n & p0_req & ~p1_gnt_s;
    end

    // Steer the granted port's fields onto the memory bus, zeros when idle.
    always_comb begin
        sel_rd_s    = 1'b0;
        sel_wr_s    = 1'b0;
        sel_addr_s  = 32'd0;
        sel_wdata_s = 32'd0;
        sel_mode_s  = '0;
        if (p1_gnt_s) begin
            sel_rd_s    = p1_rd;
            sel_wr_s    = p1_wr;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
            sel_mode_s  = p1_mode;
        end else if (p0_gnt_s) begin
            sel_rd_s    = p0_rd;
            sel_wr_s    = p0_wr;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
            sel_mode_s  = p0_mode;
        end else begin
            sel_rd_s    = 1'b0;
            sel_wr_s    = 1'b0;
        end
        // A write wins when both qualifiers are set.
        mem_write_s = sel_wr_s;
        mem_read_s  = sel_rd_s & ~sel_wr_s;
    end

    // Next-state: starvation counter, owner of this cycle's grant, read capture.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        owner_d    = OWN_NONE;
        rd_pend_d  = mem_read_s;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;

        if (!p1_req || p1_gnt_s) begin
            wait_cnt_d = {CNT_W{1'b0}};
        end else if (wait_cnt_q < CNT_W'(STARVE_LIMIT)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        if (p1_gnt_s) begin
            owner_d = OWN_P1;
        end else if (p0_gnt_s) begin
            owner_d = OWN_P0;
        end else begin
            owner_d = OWN_NONE;
        end

        // Memory data is combinational, so it is captured at the end of the grant cycle.
        if (mem_read_s && p1_gnt_s) begin
            p1_rdata_d = mem_rdata;
        end else if (mem_read_s && p0_gnt_s) begin
            p0_rdata_d = mem_rdata;
        end else begin
            p0_rdata_d = p0_rdata_q;
            p1_rdata_d = p1_rdata_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= OWN_NONE;
            wait_cnt_q <= {CNT_W{1'b0}};
            rd_pend_q  <= 1'b0;
            p0_rdata_q <= 32'd0;
            p1_rdata_q <= 32'd0;
        end else begin
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
            rd_pend_q  <= rd_pend_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    // Response valid is steered by last cycle's owner.
    always_comb begin
        p0_rvalid_s = 1'b0;
        p1_rvalid_s = 1'b0;
        case (owner_q)
            OWN_P0:  p0_rvalid_s = rd_pend_q;
            OWN_P1:  p1_rvalid_s = rd_pend_q;
            default: begin
                p0_rvalid_s = 1'b0;
                p1_rvalid_s = 1'b0;
            end
        endcase
    end

    assign p0_gnt    = p0_gnt_s;
    assign p1_gnt    = p1_gnt_s;
    assign p0_rvalid = p0_rvalid_s;
    assign p1_rvalid = p1_rvalid_s;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign mem_addr  = sel_addr_s;
    assign mem_wdata = sel_wdata_s;
    assign mem_mode  = sel_mode_s;
    assign mem_read  = mem_read_s;
    assign mem_write = mem_write_s;
    assign starve    = starve_s;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small memory model and a read-response scoreboard.
`timescale 1ns/1ps

module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_rd, p0_wr, p1_req, p1_rd, p1_wr;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [2:0]  p0_mode, p1_mode, mem_mode;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, starve;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic tb_init_done = 1'b0;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [31:0] tb_mem [0:63];

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_mode(p0_mode),
        .p0_rd(p0_rd), .p0_wr(p0_wr), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_mode(p1_mode),
        .p1_rd(p1_rd), .p1_wr(p1_wr), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mode(mem_mode),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .starve(starve)
    );

    assign mem_rdata = tb_mem[mem_addr[7:2]];

    // Memory model: preload on the first edge, then accept writes.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!tb_init_done) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= 32'd0;
            tb_mem[4] <= 32'hDEADBEEF;
        end else if (mem_write) begin
            tb_mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every cycle either the due response appears or both rvalids are low.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            mon_e = exp_q.pop_front();
            if (mon_e.port == 0) begin
                chk1("p0_rvalid", p0_rvalid, 1'b1);
                chk32("p0_rdata", p0_rdata, mon_e.data);
                chk1("p1_rvalid_quiet", p1_rvalid, 1'b0);
            end else begin
                chk1("p1_rvalid", p1_rvalid, 1'b1);
                chk32("p1_rdata", p1_rdata, mon_e.data);
                chk1("p0_rvalid_quiet", p0_rvalid, 1'b0);
            end
        end else begin
            chk1("p0_rvalid_quiet", p0_rvalid, 1'b0);
            chk1("p1_rvalid_quiet", p1_rvalid, 1'b0);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic req, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] mode);
        p0_req = req; p0_rd = rd; p0_wr = wr; p0_addr = addr; p0_wdata = wdata; p0_mode = mode;
    endtask

    task automatic set_p1(input logic req, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] mode);
        p1_req = req; p1_rd = rd; p1_wr = wr; p1_addr = addr; p1_wdata = wdata; p1_mode = mode;
    endtask

    task automatic push_exp(input int port, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        e.due  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic chk_idle_bus(input string tag);
        chk1({tag, "_p0_gnt"}, p0_gnt, 1'b0);
        chk1({tag, "_p1_gnt"}, p1_gnt, 1'b0);
        chk1({tag, "_mem_read"}, mem_read, 1'b0);
        chk1({tag, "_mem_write"}, mem_write, 1'b0);
        chk1({tag, "_starve"}, starve, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_p0(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 3'd0);
        set_p1(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, 3'd0);
        #3;
        chk_idle_bus("reset");
        chk32("reset_p0_rdata", p0_rdata, 32'd0);
        chk32("reset_p1_rdata", p1_rdata, 32'd0);
        next_cycle();
        tb_init_done = 1'b1;
        next_cycle();

        // First cycle out of reset: p0 read 0x10, p1 idle.
        rst_n = 1'b1;
        set_p0(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 3'd2);
        set_p1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        #2;
        chk1("rd_p0_gnt", p0_gnt, 1'b1);
        chk1("rd_p1_gnt", p1_gnt, 1'b0);
        chk1("rd_mem_read", mem_read, 1'b1);
        chk1("rd_mem_write", mem_write, 1'b0);
        chk32("rd_mem_addr", mem_addr, 32'h10);
        chk32("rd_mem_mode", {29'd0, mem_mode}, 32'd2);
        push_exp(0, 32'hDEADBEEF);
        next_cycle();

        // Back-to-back write on the same port while the read response is out.
        set_p0(1'b1, 1'b0, 1'b1, 32'h24, 32'hA5A50001, 3'd1);
        #2;
        chk1("b2b_p0_gnt", p0_gnt, 1'b1);
        chk1("b2b_mem_write", mem_write, 1'b1);
        chk1("b2b_mem_read", mem_read, 1'b0);
        chk32("b2b_mem_wdata", mem_wdata, 32'hA5A50001);
        next_cycle();

        // Idle bus drives zeros; read data holds.
        set_p0(1'b0, 1'b0, 1'b0, 32'h24, 32'h1111, 3'd3);
        #2;
        chk_idle_bus("idle1");
        chk32("idle_mem_addr", mem_addr, 32'd0);
        chk32("idle_mem_wdata", mem_wdata, 32'd0);
        chk32("idle_mem_mode", {29'd0, mem_mode}, 32'd0);
        chk32("hold_p0_rdata", p0_rdata, 32'hDEADBEEF);
        next_cycle();
        set_p0(1'b1, 1'b1, 1'b0, 32'h24, 32'd0, 3'd0);
        #2;
        chk1("rd24_p0_gnt", p0_gnt, 1'b1);
        push_exp(0, 32'hA5A50001);
        next_cycle();

        // Contention: p0 wins STARVE_LIMIT cycles, then p1 once.
        set_p0(1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 3'd0);
        set_p1(1'b1, 1'b0, 1'b0, 32'h4, 32'd0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk1("contend_p0_gnt", p0_gnt, 1'b1);
            chk1("contend_p1_gnt", p1_gnt, 1'b0);
            chk1("contend_starve", starve, 1'b0);
            chk1("nop_mem_read", mem_read, 1'b0);
            chk1("nop_mem_write", mem_write, 1'b0);
            next_cycle();
        end
        #2;
        chk1("starve_flag", starve, 1'b1);
        chk1("starve_p1_gnt", p1_gnt, 1'b1);
        chk1("starve_p0_gnt", p0_gnt, 1'b0);
        next_cycle();
        #2;
        chk1("after_starve_flag", starve, 1'b0);
        chk1("after_starve_p0_gnt", p0_gnt, 1'b1);
        next_cycle();

        // Dropping p1_req for a cycle clears the partial count.
        p1_req = 1'b0;
        next_cycle();
        p1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk1("clr_p0_gnt", p0_gnt, 1'b1);
            chk1("clr_p1_gnt", p1_gnt, 1'b0);
            next_cycle();
        end
        #2;
        chk1("clr_p1_win", p1_gnt, 1'b1);
        next_cycle();

        // p1 write then read back through the memory model.
        set_p0(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 3'd0);
        set_p1(1'b1, 1'b0, 1'b1, 32'h20, 32'h12345678, 3'd2);
        #2;
        chk1("p1wr_gnt", p1_gnt, 1'b1);
        chk1("p1wr_mem_write", mem_write, 1'b1);
        chk32("p1wr_mem_addr", mem_addr, 32'h20);
        chk32("p1wr_mem_wdata", mem_wdata, 32'h12345678);
        next_cycle();
        set_p1(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, 3'd2);
        #2;
        chk1("p1rd_gnt", p1_gnt, 1'b1);
        chk1("p1rd_mem_read", mem_read, 1'b1);
        push_exp(1, 32'h12345678);
        next_cycle();
        set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 3'd0);
        next_cycle();

        // rd and wr both set: write only, no response.
        set_p0(1'b1, 1'b1, 1'b1, 32'h28, 32'hCAFE0001, 3'd0);
        #2;
        chk1("rdwr_p0_gnt", p0_gnt, 1'b1);
        chk1("rdwr_mem_write", mem_write, 1'b1);
        chk1("rdwr_mem_read", mem_read, 1'b0);
        next_cycle();
        set_p0(1'b1, 1'b1, 1'b0, 32'h28, 32'd0, 3'd0);
        #2;
        push_exp(0, 32'hCAFE0001);
        next_cycle();
        set_p0(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 3'd0);
        next_cycle();

        // Reset pulse during a granted p1 read drops the response.
        set_p1(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, 3'd0);
        #2;
        chk1("rstmid_p1_gnt", p1_gnt, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_idle_bus("rstmid");
        chk32("rstmid_p1_rdata", p1_rdata, 32'd0);
        chk32("rstmid_mem_addr", mem_addr, 32'd0);
        next_cycle();
        #2;
        chk_idle_bus("rsthold");
        chk1("rsthold_p1_rvalid", p1_rvalid, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        #2;
        chk1("rstrel_p1_gnt", p1_gnt, 1'b1);
        chk1("rstrel_mem_read", mem_read, 1'b1);
        push_exp(1, 32'h12345678);
        next_cycle();
        set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 3'd0);

        // Ten idle cycles.
        for (int i = 0; i < 10; i++) begin
            #2;
            chk_idle_bus("quiet");
            next_cycle();
        end
        set_p0(1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 3'd0);
        set_p1(1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 3'd0);
        #2;
        chk1("quiet_then_p0_gnt", p0_gnt, 1'b1);
        chk1("quiet_then_starve", starve, 1'b0);
        next_cycle();
        set_p0(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 3'd0);
        set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 3'd0);
        next_cycle();
        next_cycle();

        chk32("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
